// File: rtl/memory_reader.sv
// memory_reader: DFF word array with a bit-serial valid/ready read-out.
// Define MEMORY_READER_PARITY_EN to append an even-parity bit per word.
module memory_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [AW-1:0]    SA,
  input  logic [AW-1:0]    LEN,
  input  logic             RDY,
  output logic             Q,
  output logic             _Q,
  output logic             QV,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH);

`ifdef MEMORY_READER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd3
  } state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sh;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    words;
  logic [BW-1:0]    bitcnt;
`ifdef MEMORY_READER_PARITY_EN
  logic             par;
`endif

  logic xfer;
  logic last;
  logic load_start;
  logic load_next;
  logic shift;

  assign xfer = QV & RDY;
  assign last = (bitcnt == BW'(WIDTH - 1));

  // State register; reset aborts any stream without a DONE pulse.
  always_ff @(posedge C) begin
    if (R) state <= IDLE;
    else   state <= state_n;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_n    = state;
    load_start = 1'b0;
    load_next  = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          load_start = 1'b1;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          shift = 1'b1;
          if (last) begin
`ifdef MEMORY_READER_PARITY_EN
            state_n = PAR;
`else
            if (words != '0) load_next = 1'b1;
            else             state_n   = FIN;
`endif
          end
        end
      end
`ifdef MEMORY_READER_PARITY_EN
      PAR: begin
        if (xfer) begin
          if (words != '0) begin
            load_next = 1'b1;
            state_n   = SHIFT;
          end else begin
            state_n = FIN;
          end
        end
      end
`endif
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Storage array and shifter; loads read pre-write contents.
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sh     <= '0;
      ptr    <= '0;
      words  <= '0;
      bitcnt <= '0;
`ifdef MEMORY_READER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      if (WE) mem[WA] <= D;
      if (load_start) begin
        sh     <= mem[SA];
        ptr    <= SA + 1'b1;
        words  <= LEN;
        bitcnt <= '0;
`ifdef MEMORY_READER_PARITY_EN
        par    <= ^mem[SA];
`endif
      end else if (load_next) begin
        sh     <= mem[ptr];
        ptr    <= ptr + 1'b1;
        words  <= words - 1'b1;
        bitcnt <= '0;
`ifdef MEMORY_READER_PARITY_EN
        par    <= ^mem[ptr];
`endif
      end else if (shift) begin
        sh     <= sh >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end

  // Serial outputs, forced low outside the streaming states.
  always_comb begin
    Q  = 1'b0;
    QV = 1'b0;
    if (state == SHIFT) begin
      Q  = sh[0];
      QV = 1'b1;
    end
`ifdef MEMORY_READER_PARITY_EN
    if (state == PAR) begin
      Q  = par;
      QV = 1'b1;
    end
`endif
  end

  assign _Q   = ~Q;
  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);

endmodule
